// File: rtl/relay_pkg.sv
// Shared types and helpers for the latching relay coil pulse controller.
package relay_pkg;

    localparam int NUM_RELAYS = 4;

    typedef enum logic [2:0] {
        IDLE,
        DEAD_PRE,
        PULSE,
        DEAD_POST,
        HOLDOFF
    } relay_state_t;

    typedef struct packed {
        logic       dir;
        logic [1:0] ch;
    } relay_req_t;

    // Width of a down-counter able to hold the largest of three cycle counts.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/relay_req_slot.sv
// One-deep pending request holder; a push into a full slot is dropped
// and flagged, keeping the request already held.
module relay_req_slot
    import relay_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  relay_req_t push_req,
    input  logic       pop,
    output logic       valid,
    output logic       valid_next,
    output relay_req_t req,
    output logic       overflow
);

    logic       valid_q, valid_d;
    relay_req_t req_q, req_d;
    logic       overflow_q, overflow_d;

    // Next slot contents: a pop frees the slot, so a same-cycle push refills it.
    always_comb begin
        valid_d    = valid_q;
        req_d      = req_q;
        overflow_d = 1'b0;
        if (pop) begin
            valid_d = 1'b0;
        end
        if (push) begin
            if (valid_q && !pop) begin
                overflow_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                req_d   = push_req;
            end
        end
    end

    // Slot and overflow strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            req_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            req_q      <= req_d;
            overflow_q <= overflow_d;
        end
    end

    assign valid      = valid_q;
    assign valid_next = valid_d;
    assign req        = req_q;
    assign overflow   = overflow_q;

endmodule

// File: rtl/relay_pulse_controller.sv
// Turns one-cycle relay requests into dead-time guarded H-bridge coil pulses
// for four latching relays, with one request queued behind the active one.
module relay_pulse_controller
    import relay_pkg::*;
#(
    parameter int PULSE_CYCLES   = 2500000,
    parameter int DEAD_CYCLES    = 250,
    parameter int HOLDOFF_CYCLES = 25000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  relay_en,
    input  logic                  relay_dir,
    input  logic [1:0]            relay_channel,
    output logic                  relay_done,
    output logic                  busy,
    output logic                  overflow,
    output logic [NUM_RELAYS-1:0] coil_a,
    output logic [NUM_RELAYS-1:0] coil_b
);

    localparam int CNT_W = cnt_width(PULSE_CYCLES, DEAD_CYCLES, HOLDOFF_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LOAD  = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  =
        CNT_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

    relay_state_t          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    relay_req_t            active_q, active_d;
    logic [NUM_RELAYS-1:0] coil_a_q, coil_a_d;
    logic [NUM_RELAYS-1:0] coil_b_q, coil_b_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    relay_req_t new_req;
    relay_req_t pend_req;
    logic       pend_valid;
    logic       pend_valid_next;
    logic       take_pend;
    logic       take_new;

    assign new_req = '{dir: relay_dir, ch: relay_channel};

    relay_req_slot u_slot (
        .clk        (clk),
        .rst        (rst),
        .push       (relay_en && !take_new),
        .push_req   (new_req),
        .pop        (take_pend),
        .valid      (pend_valid),
        .valid_next (pend_valid_next),
        .req        (pend_req),
        .overflow   (overflow)
    );

    // Sequencer: next state, counter reload and active request selection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        take_pend = 1'b0;
        take_new  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pend_valid) begin
                    take_pend = 1'b1;
                    active_d  = pend_req;
                    state_d   = DEAD_PRE;
                    cnt_d     = DEAD_LOAD;
                end else if (relay_en) begin
                    take_new = 1'b1;
                    active_d = new_req;
                    state_d  = DEAD_PRE;
                    cnt_d    = DEAD_LOAD;
                end
            end
            DEAD_PRE: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = DEAD_POST;
                    cnt_d   = DEAD_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DEAD_POST: begin
                if (cnt_q == '0) begin
                    if (HOLDOFF_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLDOFF;
                        cnt_d   = HOLD_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered outputs are decoded from the next state so they line up
    // with the state they describe rather than lagging it by a cycle.
    always_comb begin
        coil_a_d = '0;
        coil_b_d = '0;
        if (state_d == PULSE) begin
            coil_a_d[active_d.ch] = active_d.dir;
            coil_b_d[active_d.ch] = ~active_d.dir;
        end
        done_d = (state_d == DEAD_POST) && (cnt_d == '0);
        busy_d = (state_d != IDLE) || pend_valid_next;
    end

    // State, counter, active request and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            active_q <= '0;
            coil_a_q <= '0;
            coil_b_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            coil_a_q <= coil_a_d;
            coil_b_q <= coil_b_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign coil_a     = coil_a_q;
    assign coil_b     = coil_b_q;
    assign relay_done = done_q;
    assign busy       = busy_q;

endmodule
